countdown_mm_ss: RTL
====================

COUNTDOWN_MM_SS -- requirements
Module: countdown_mm_ss

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 1: number of qualified Tick pulses per one-second decrement (1..255).
REQ-002 SHALL provide port Clk  input  1  sole clock; all state changes on its rising edge except reset.
REQ-003 SHALL provide port Clr  input  1  reset; asynchronous, active-low.
REQ-004 SHALL provide port Enable  input  1  global qualifier; all inputs except Clr are ignored while low.
REQ-005 SHALL provide port LD  input  1  load IN_MIN/IN_SEC into the count.
REQ-006 SHALL provide port IN_MIN  input  8  preset minutes, two BCD digits.
REQ-007 SHALL provide port IN_SEC  input  8  preset seconds, two BCD digits.
REQ-008 SHALL provide port Start  input  1  begin or resume countdown.
REQ-009 SHALL provide port Stop  input  1  halt countdown and clear expiry.
REQ-010 SHALL provide port Tick  input  1  one-cycle timebase pulse.
REQ-011 SHALL provide port MIN  output  8  current minutes, BCD, registered.
REQ-012 SHALL provide port SEC  output  8  current seconds, BCD, registered.
REQ-013 SHALL provide port RUNNING  output  1  high in state RUN.
REQ-014 SHALL provide port EXPIRED  output  1  high in state EXPIRED.
REQ-015 SHALL provide port DONE  output  1  one-cycle pulse on reaching 00:00.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, EXPIRED; RUNNING/EXPIRED decoded from registered state.
REQ-017 Input priority per edge SHALL be: Clr > LD > Stop > Start > Tick.
REQ-018 LD (with Enable) in any state SHALL load the clamped preset, clear the tick divider, and enter IDLE.
REQ-019 Clamping SHALL be: any units digit >9 -> 9; seconds tens >5 -> 5; minutes tens >9 -> 9.
REQ-020 Start in IDLE SHALL enter RUN and clear the tick divider, unless count is 00:00, in which case the block stays IDLE.
REQ-021 Stop SHALL enter IDLE from RUN or EXPIRED and hold the count.
REQ-022 In RUN, each qualified Tick SHALL advance the divider; on the TICK_DIV-th one the divider clears and the count decrements by one second.
REQ-023 Decrement: SEC units >0 -> units-1; else SEC tens >0 -> tens-1, units=9; else SEC=59 and MIN decrements with the same BCD borrow.
REQ-024 The edge whose decrement yields 00:00 SHALL assert DONE for exactly the following cycle.
REQ-025 Ticks in IDLE or EXPIRED SHALL not alter count or divider.
REQ-026 Enable low SHALL freeze state, count and divider; DONE SHALL deassert normally.
REQ-027 MIN/SEC SHALL change only on clock edges; never hold non-BCD values.

Reset
REQ-028 Clr low SHALL immediately force MIN=8'h00, SEC=8'h00, state IDLE, divider 0, DONE=0, reload register 00:00, independent of Clk and Enable.
REQ-029 Reset mid-countdown SHALL abandon the run; no DONE SHALL be produced.

Configuration
REQ-030 Macro COUNTDOWN_RELOAD_EN defined: block SHALL keep a reload register written on every LD; on reaching 00:00 DONE pulses, count reloads on the same edge, state remains RUN, EXPIRED never asserts.
REQ-031 Macro COUNTDOWN_RELOAD_EN undefined: no reload register; on reaching 00:00 state becomes EXPIRED holding 00:00 until LD, Stop or Clr.

Verification
REQ-032 LD with IN_MIN=8'h10, IN_SEC=8'h00, Start, one Tick (TICK_DIV=1) -> MIN=8'h09, SEC=8'h59.
REQ-033 Load 00:02, Start, two Ticks, macro off -> 00:00, DONE high one cycle, EXPIRED=1; further Ticks leave 00:00; Stop -> IDLE, EXPIRED=0.
REQ-034 Macro on, load 00:03, Start, three Ticks -> DONE pulse, MIN/SEC=00:03, RUNNING=1.
REQ-035 Load 01:30, Start, five Ticks, Clr low between edges -> outputs 00:00, RUNNING=0 immediately, no DONE.
REQ-036 In RUN, LD and Tick same edge with IN_SEC=8'h7B, IN_MIN=8'h00 -> SEC=8'h59, MIN=8'h00, IDLE; Enable low during later Start/Tick -> no change.

Source files
------------

// File: rtl/countdown_mm_ss.sv
// -----------------------------------------------------------------------------
// countdown_mm_ss
//   Minutes:seconds countdown timer with BCD count registers.
//   A preset is loaded (digit-clamped to legal BCD), Start begins counting down
//   one second per TICK_DIV qualified Tick pulses, and reaching 00:00 pulses
//   DONE for one cycle.
//
//   Optional feature macro: COUNTDOWN_RELOAD_EN
//     undefined : reaching 00:00 moves to EXPIRED and holds 00:00.
//     defined   : the last loaded preset is kept in a reload register; reaching
//                 00:00 pulses DONE, reloads the count and keeps running.
//
// Parameters
//   TICK_DIV  qualified Tick pulses per one-second decrement (1..255)
//
// Ports
//   Clk      in   clock, rising edge
//   Clr      in   asynchronous active-low reset
//   Enable   in   global qualifier; all other inputs ignored while low
//   LD       in   load IN_MIN/IN_SEC, enter IDLE
//   IN_MIN   in   [7:0] preset minutes, BCD
//   IN_SEC   in   [7:0] preset seconds, BCD
//   Start    in   begin/resume countdown from IDLE
//   Stop     in   return to IDLE, holding the count
//   Tick     in   one-cycle timebase pulse
//   MIN      out  [7:0] current minutes, BCD
//   SEC      out  [7:0] current seconds, BCD
//   RUNNING  out  state is RUN
//   EXPIRED  out  state is EXPIRED
//   DONE     out  one-cycle pulse after the count reaches 00:00
// -----------------------------------------------------------------------------
module countdown_mm_ss #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       Enable,
    input  logic       LD,
    input  logic [7:0] IN_MIN,
    input  logic [7:0] IN_SEC,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Tick,
    output logic [7:0] MIN,
    output logic [7:0] SEC,
    output logic       RUNNING,
    output logic       EXPIRED,
    output logic       DONE
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_min, w_min_nxt;
    logic [7:0] r_sec, w_sec_nxt;
    logic [7:0] r_div, w_div_nxt;
    logic       r_done, w_done_nxt;

    logic [7:0] w_ld_min, w_ld_sec;
    logic [7:0] w_dec_min, w_dec_sec;
    logic       w_cnt_zero, w_dec_zero;

`ifdef COUNTDOWN_RELOAD_EN
    logic [7:0] r_rel_min, w_rel_min_nxt;
    logic [7:0] r_rel_sec, w_rel_sec_nxt;
`endif

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Two-digit BCD decrement with borrow from tens; 00 stays 00 so the
    // registers can never pick up a non-BCD digit.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] != 4'd0)
            return {v[7:4], v[3:0] - 4'd1};
        else if (v[7:4] != 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return 8'h00;
    endfunction

    assign w_ld_min = {clamp_digit(IN_MIN[7:4], 4'd9), clamp_digit(IN_MIN[3:0], 4'd9)};
    assign w_ld_sec = {clamp_digit(IN_SEC[7:4], 4'd5), clamp_digit(IN_SEC[3:0], 4'd9)};

    // Seconds wrap 00 -> 59 and borrow one minute.
    assign w_dec_sec  = (r_sec == 8'h00) ? 8'h59 : bcd_dec(r_sec);
    assign w_dec_min  = (r_sec == 8'h00) ? bcd_dec(r_min) : r_min;
    assign w_cnt_zero = (r_min == 8'h00) && (r_sec == 8'h00);
    assign w_dec_zero = (w_dec_min == 8'h00) && (w_dec_sec == 8'h00);

    // Next-state: the highest-priority asserted input (LD > Stop > Start > Tick)
    // alone decides the edge; lower-priority inputs on the same edge are ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_div_nxt   = r_div;
        w_done_nxt  = 1'b0;
`ifdef COUNTDOWN_RELOAD_EN
        w_rel_min_nxt = r_rel_min;
        w_rel_sec_nxt = r_rel_sec;
`endif
        if (Enable) begin
            if (LD) begin
                w_min_nxt   = w_ld_min;
                w_sec_nxt   = w_ld_sec;
                w_div_nxt   = 8'd0;
                w_state_nxt = ST_IDLE;
`ifdef COUNTDOWN_RELOAD_EN
                w_rel_min_nxt = w_ld_min;
                w_rel_sec_nxt = w_ld_sec;
`endif
            end else if (Stop) begin
                w_state_nxt = ST_IDLE;
            end else if (Start) begin
                if (r_state == ST_IDLE && !w_cnt_zero) begin
                    w_state_nxt = ST_RUN;
                    w_div_nxt   = 8'd0;
                end
            end else if (Tick && r_state == ST_RUN) begin
                if (r_div >= DIV_LAST) begin
                    w_div_nxt = 8'd0;
                    w_min_nxt = w_dec_min;
                    w_sec_nxt = w_dec_sec;
                    if (w_dec_zero) begin
                        w_done_nxt = 1'b1;
`ifdef COUNTDOWN_RELOAD_EN
                        w_min_nxt = r_rel_min;
                        w_sec_nxt = r_rel_sec;
`else
                        w_state_nxt = ST_EXPIRED;
`endif
                    end
                end else begin
                    w_div_nxt = r_div + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_state <= ST_IDLE;
            r_min   <= 8'h00;
            r_sec   <= 8'h00;
            r_div   <= 8'd0;
            r_done  <= 1'b0;
`ifdef COUNTDOWN_RELOAD_EN
            r_rel_min <= 8'h00;
            r_rel_sec <= 8'h00;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_min   <= w_min_nxt;
            r_sec   <= w_sec_nxt;
            r_div   <= w_div_nxt;
            r_done  <= w_done_nxt;
`ifdef COUNTDOWN_RELOAD_EN
            r_rel_min <= w_rel_min_nxt;
            r_rel_sec <= w_rel_sec_nxt;
`endif
        end
    end

    assign MIN     = r_min;
    assign SEC     = r_sec;
    assign RUNNING = (r_state == ST_RUN);
    assign EXPIRED = (r_state == ST_EXPIRED);
    assign DONE    = r_done;

endmodule
